// File: rtl/cpu_control_if.sv
// rtl/cpu_control_if.sv - memory handshake bundle between cpu_control and the single-port memory
//
// mem_read / mem_write : request strobes, held for every cycle of a transaction
// mem_byte_enable      : write lane mask, 4'b1111 outside sub-word stores
// mem_resp             : one-cycle completion pulse from memory
// mem_addr_lo          : MAR[1:0], selects the store lanes
interface cpu_control_if;
  logic       mem_read;
  logic       mem_write;
  logic [3:0] mem_byte_enable;
  logic       mem_resp;
  logic [1:0] mem_addr_lo;

  modport master (
    output mem_read, mem_write, mem_byte_enable,
    input  mem_resp, mem_addr_lo
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable,
    output mem_resp, mem_addr_lo
  );
endinterface

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - multicycle Moore control FSM for the RV32I datapath
//
// Inputs : clk, rst_n (async, active low), IR fields opcode/funct3/funct7,
//          br_en from the comparator, memory handshake via the mem interface.
// Outputs: datapath load enables, mux selects, aluop/cmpop, and through the
//          mem interface the read/write requests and store byte enables.
module cpu_control (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 br_en,
  cpu_control_if.master        mem,
  output logic                 load_pc,
  output logic                 load_ir,
  output logic                 load_regfile,
  output logic                 load_mar,
  output logic                 load_mdr,
  output logic                 load_data_out,
  output logic                 pcmux_sel,
  output logic                 jalr,
  output logic                 alumux1_sel,
  output logic [2:0]           alumux2_sel,
  output logic                 marmux_sel,
  output logic                 cmpmux_sel,
  output logic [3:0]           regfilemux_sel,
  output logic [2:0]           aluop,
  output logic [2:0]           cmpop
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SRA = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] CMP_BLT  = 3'd4;
  localparam logic [2:0] CMP_BLTU = 3'd6;

  typedef enum logic [3:0] {
    S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_LUI, S_AUIPC, S_JAL, S_JALR, S_BR,
    S_IMM, S_REG, S_CALC_ADDR, S_LD1, S_LD2, S_ST1, S_ST2
  } state_e;

  state_e state_q, state_d;

  logic f7_b5;
  logic unused_funct7;
  assign f7_b5         = funct7[5];
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH1;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    load_pc             = 1'b0;
    load_ir             = 1'b0;
    load_regfile        = 1'b0;
    load_mar            = 1'b0;
    load_mdr            = 1'b0;
    load_data_out       = 1'b0;
    pcmux_sel           = 1'b0;
    jalr                = 1'b0;
    alumux1_sel         = 1'b0;
    alumux2_sel         = 3'd0;
    marmux_sel          = 1'b0;
    cmpmux_sel          = 1'b0;
    regfilemux_sel      = 4'd0;
    aluop               = ALU_ADD;
    cmpop               = 3'd0;
    mem.mem_read        = 1'b0;
    mem.mem_write       = 1'b0;
    mem.mem_byte_enable = 4'b1111;

    unique case (state_q)
      S_FETCH1: begin
        load_mar = 1'b1;
        state_d  = S_FETCH2;
      end
      S_FETCH2: begin
        mem.mem_read = 1'b1;
        load_mdr     = 1'b1;
        if (mem.mem_resp) state_d = S_FETCH3;
      end
      S_FETCH3: begin
        load_ir = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LUI:             state_d = S_LUI;
          OP_AUIPC:           state_d = S_AUIPC;
          OP_JAL:             state_d = S_JAL;
          OP_JALR:            state_d = S_JALR;
          OP_BR:              state_d = S_BR;
          OP_LOAD, OP_STORE:  state_d = S_CALC_ADDR;
          OP_IMM:             state_d = S_IMM;
          OP_REG:             state_d = S_REG;
          default:            state_d = S_FETCH1;
        endcase
      end
      S_LUI: begin
        regfilemux_sel = 4'd2;
        load_regfile   = 1'b1;
        load_pc        = 1'b1;
        state_d        = S_FETCH1;
      end
      S_AUIPC: begin
        alumux1_sel  = 1'b1;
        alumux2_sel  = 3'd1;
        load_regfile = 1'b1;
        load_pc      = 1'b1;
        state_d      = S_FETCH1;
      end
      S_JAL, S_JALR: begin
        // rd gets pc+4 from the regfile mux while the PC takes the ALU target
        regfilemux_sel = 4'd4;
        load_regfile   = 1'b1;
        alumux1_sel    = (state_q == S_JAL);
        alumux2_sel    = (state_q == S_JAL) ? 3'd4 : 3'd0;
        jalr           = (state_q == S_JALR);
        pcmux_sel      = 1'b1;
        load_pc        = 1'b1;
        state_d        = S_FETCH1;
      end
      S_BR: begin
        alumux1_sel = 1'b1;
        alumux2_sel = 3'd2;
        cmpop       = funct3;
        pcmux_sel   = br_en;
        load_pc     = 1'b1;
        state_d     = S_FETCH1;
      end
      S_IMM, S_REG: begin
        alumux2_sel  = (state_q == S_REG) ? 3'd5 : 3'd0;
        load_regfile = 1'b1;
        load_pc      = 1'b1;
        state_d      = S_FETCH1;
        case (funct3)
          3'd2, 3'd3: begin
            regfilemux_sel = 4'd1;
            cmpop          = (funct3 == 3'd2) ? CMP_BLT : CMP_BLTU;
            cmpmux_sel     = (state_q == S_IMM);
          end
          // funct7[5] is immediate data for addi, so only REG decodes sub
          3'd0:    aluop = (state_q == S_REG && f7_b5) ? ALU_SUB : ALU_ADD;
          3'd5:    aluop = f7_b5 ? ALU_SRA : funct3;
          default: aluop = funct3;
        endcase
      end
      S_CALC_ADDR: begin
        marmux_sel    = 1'b1;
        load_mar      = 1'b1;
        alumux2_sel   = (opcode == OP_STORE) ? 3'd3 : 3'd0;
        load_data_out = (opcode == OP_STORE);
        state_d       = (opcode == OP_STORE) ? S_ST1 : S_LD1;
      end
      S_LD1: begin
        mem.mem_read = 1'b1;
        load_mdr     = 1'b1;
        if (mem.mem_resp) state_d = S_LD2;
      end
      S_LD2: begin
        load_regfile = 1'b1;
        load_pc      = 1'b1;
        state_d      = S_FETCH1;
        case (funct3)
          3'd0:    regfilemux_sel = 4'd7;
          3'd1:    regfilemux_sel = 4'd5;
          3'd4:    regfilemux_sel = 4'd8;
          3'd5:    regfilemux_sel = 4'd6;
          default: regfilemux_sel = 4'd3;
        endcase
      end
      S_ST1: begin
        mem.mem_write = 1'b1;
        case (funct3)
          3'd0:    mem.mem_byte_enable = 4'b0001 << mem.mem_addr_lo;
          3'd1:    mem.mem_byte_enable = 4'b0011 << mem.mem_addr_lo;
          default: mem.mem_byte_enable = 4'b1111;
        endcase
        if (mem.mem_resp) state_d = S_ST2;
      end
      S_ST2: begin
        load_pc = 1'b1;
        state_d = S_FETCH1;
      end
      default: state_d = S_FETCH1;
    endcase

    // FETCH1 would otherwise show load_mar while reset is held
    if (!rst_n) begin
      load_pc       = 1'b0;
      load_ir       = 1'b0;
      load_regfile  = 1'b0;
      load_mar      = 1'b0;
      load_mdr      = 1'b0;
      load_data_out = 1'b0;
      mem.mem_read  = 1'b0;
      mem.mem_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// tb/tb_cpu_control.sv - self-checking bench for cpu_control
module tb_cpu_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       br_en;
  logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
  logic       pcmux_sel, jalr, alumux1_sel, marmux_sel, cmpmux_sel;
  logic [2:0] alumux2_sel, aluop, cmpop;
  logic [3:0] regfilemux_sel;

  cpu_control_if mem_if ();

  cpu_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .mem(mem_if.master),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
    .pcmux_sel(pcmux_sel), .jalr(jalr), .alumux1_sel(alumux1_sel),
    .alumux2_sel(alumux2_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
    .regfilemux_sel(regfilemux_sel), .aluop(aluop), .cmpop(cmpop)
  );

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       br;
    logic [1:0] alo;
  } instr_t;

  typedef struct {
    int cycles; int n_rw; int n_pc; int n_ir; int n_rd; int n_wr; int overlap;
    int rf; int aluop; int a1; int a2; int pcmux; int jalr; int cmpop; int cmpmux; int be;
  } res_t;

  typedef struct {
    instr_t in;
    int rf; int aluop; int a2; int pcmux; int n_rw; int be; int cycles;
  } vec_t;

  int checks = 0;
  int passed = 0;
  bit rand_resp = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One instruction from FETCH1 to the next FETCH1; entered and left at the
  // negedge of a FETCH1 cycle. The memory answers after fw (fetch) or dw (data)
  // wait cycles; the IR fields change only when load_ir is seen.
  task automatic run_instr(input instr_t in, input int fw, input int dw, output res_t r);
    int  waitc;
    bit  ir_seen, set_ir, done;
    r = '{default: 0};
    waitc = 0; ir_seen = 0; done = 0;
    br_en = in.br;
    mem_if.mem_addr_lo = in.alo;
    while (!done) begin
      r.cycles++;
      if (load_regfile) r.n_rw++;
      if (load_ir) r.n_ir++;
      if (mem_if.mem_read) r.n_rd++;
      if (mem_if.mem_write) begin r.n_wr++; r.be = int'(mem_if.mem_byte_enable); end
      if (mem_if.mem_read && mem_if.mem_write) r.overlap = 1;
      if (load_pc) begin
        r.n_pc++;
        r.rf = int'(regfilemux_sel); r.aluop = int'(aluop); r.a1 = int'(alumux1_sel);
        r.a2 = int'(alumux2_sel); r.pcmux = int'(pcmux_sel); r.jalr = int'(jalr);
        r.cmpop = int'(cmpop); r.cmpmux = int'(cmpmux_sel);
      end
      set_ir = load_ir;
      if (mem_if.mem_read || mem_if.mem_write) begin
        if (waitc == (ir_seen ? dw : fw)) begin mem_if.mem_resp = 1'b1; waitc = 0; end
        else waitc++;
      end else begin
        mem_if.mem_resp = rand_resp ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(posedge clk); #1;
      mem_if.mem_resp = 1'b0;
      if (set_ir) begin ir_seen = 1; opcode = in.op; funct3 = in.f3; funct7 = in.f7; end
      @(negedge clk);
      if (load_mar && !marmux_sel) done = 1;
      else if (r.cycles >= 40) begin
        checks++;
        $display("FAIL run_bound: no return to fetch after %0d cycles, limit 40", r.cycles);
        done = 1;
      end
    end
  endtask

  // Expected behaviour of one instruction, from the instruction semantics.
  function automatic res_t exp_of(input instr_t in, input int fw, input int dw);
    res_t e;
    bit   is_reg;
    int   ld_rf[8];
    ld_rf = '{7, 5, 3, 3, 8, 6, 3, 3};
    e = '{default: 0};
    e.n_ir = 1; e.n_pc = 1; e.n_rd = fw + 1; e.cycles = 5 + fw;
    case (in.op)
      7'h37: begin e.n_rw = 1; e.rf = 2; end
      7'h17: begin e.n_rw = 1; e.a1 = 1; e.a2 = 1; end
      7'h6F: begin e.n_rw = 1; e.rf = 4; e.a1 = 1; e.a2 = 4; e.pcmux = 1; end
      7'h67: begin e.n_rw = 1; e.rf = 4; e.jalr = 1; e.pcmux = 1; end
      7'h63: begin e.a1 = 1; e.a2 = 2; e.cmpop = int'(in.f3); e.pcmux = int'(in.br); end
      7'h13, 7'h33: begin
        is_reg = (in.op == 7'h33);
        e.n_rw = 1;
        e.a2 = is_reg ? 5 : 0;
        if (in.f3 == 3'd2 || in.f3 == 3'd3) begin
          e.rf = 1;
          e.cmpop = (in.f3 == 3'd2) ? 4 : 6;
          e.cmpmux = is_reg ? 0 : 1;
        end else if (in.f3 == 3'd0 && is_reg && in.f7[5]) e.aluop = 3;
        else if (in.f3 == 3'd5 && in.f7[5]) e.aluop = 2;
        else e.aluop = int'(in.f3);
      end
      7'h03: begin
        e.cycles = 7 + fw + dw; e.n_rw = 1; e.n_rd += dw + 1; e.rf = ld_rf[in.f3];
      end
      7'h23: begin
        e.cycles = 7 + fw + dw; e.n_wr = dw + 1;
        if (in.f3 == 3'd0) e.be = (1 << in.alo) & 15;
        else if (in.f3 == 3'd1) e.be = (3 << in.alo) & 15;
        else e.be = 15;
      end
      default: begin e.cycles = 4 + fw; e.n_pc = 0; end
    endcase
    return e;
  endfunction

  task automatic cmp_all(input string tag, input res_t a, input res_t e);
    chk($sformatf("%s.cycles", tag), a.cycles, e.cycles);
    chk($sformatf("%s.n_regwr", tag), a.n_rw, e.n_rw);
    chk($sformatf("%s.n_pcld", tag), a.n_pc, e.n_pc);
    chk($sformatf("%s.n_irld", tag), a.n_ir, e.n_ir);
    chk($sformatf("%s.n_read", tag), a.n_rd, e.n_rd);
    chk($sformatf("%s.n_write", tag), a.n_wr, e.n_wr);
    chk($sformatf("%s.rd_wr_overlap", tag), a.overlap, 0);
    chk($sformatf("%s.regfilemux", tag), a.rf, e.rf);
    chk($sformatf("%s.aluop", tag), a.aluop, e.aluop);
    chk($sformatf("%s.alumux1", tag), a.a1, e.a1);
    chk($sformatf("%s.alumux2", tag), a.a2, e.a2);
    chk($sformatf("%s.pcmux", tag), a.pcmux, e.pcmux);
    chk($sformatf("%s.jalr", tag), a.jalr, e.jalr);
    chk($sformatf("%s.cmpop", tag), a.cmpop, e.cmpop);
    chk($sformatf("%s.cmpmux", tag), a.cmpmux, e.cmpmux);
    chk($sformatf("%s.byte_en", tag), a.be, e.be);
  endtask

  function automatic instr_t rand_instr();
    instr_t in;
    int     k;
    k = $urandom_range(0, 9);
    in.f3 = 3'($urandom_range(0, 7));
    in.f7 = 7'($urandom);
    in.br = 1'($urandom);
    in.alo = 2'($urandom);
    case (k)
      0: in.op = 7'h37;
      1: in.op = 7'h17;
      2: in.op = 7'h6F;
      3: in.op = 7'h67;
      4: begin in.op = 7'h63; if (in.f3 == 3'd2 || in.f3 == 3'd3) in.f3 = 3'd0; end
      5: in.op = 7'h13;
      6: in.op = 7'h33;
      7: begin in.op = 7'h03; if (in.f3 == 3'd3 || in.f3 > 3'd5) in.f3 = 3'd2; end
      8: begin in.op = 7'h23; in.f3 = 3'($urandom_range(0, 2)); end
      default: begin
        case ($urandom_range(0, 3))
          0: in.op = 7'h7F;
          1: in.op = 7'h00;
          2: in.op = 7'h73;
          default: in.op = 7'h0F;
        endcase
      end
    endcase
    return in;
  endfunction

  vec_t   vecs[17];
  res_t   r;
  instr_t in;
  int     fw, dw;

  initial begin
    vecs[0]  = '{'{7'h13, 3'd0, 7'h20, 1'b0, 2'd0}, 0, 0, 0, 0, 1, 0, 5};
    vecs[1]  = '{'{7'h33, 3'd0, 7'h20, 1'b0, 2'd0}, 0, 3, 5, 0, 1, 0, 5};
    vecs[2]  = '{'{7'h33, 3'd5, 7'h20, 1'b0, 2'd0}, 0, 2, 5, 0, 1, 0, 5};
    vecs[3]  = '{'{7'h13, 3'd5, 7'h20, 1'b0, 2'd0}, 0, 2, 0, 0, 1, 0, 5};
    vecs[4]  = '{'{7'h33, 3'd3, 7'h00, 1'b0, 2'd0}, 1, 0, 5, 0, 1, 0, 5};
    vecs[5]  = '{'{7'h13, 3'd2, 7'h00, 1'b0, 2'd0}, 1, 0, 0, 0, 1, 0, 5};
    vecs[6]  = '{'{7'h63, 3'd0, 7'h00, 1'b1, 2'd0}, 0, 0, 2, 1, 0, 0, 5};
    vecs[7]  = '{'{7'h63, 3'd0, 7'h00, 1'b0, 2'd0}, 0, 0, 2, 0, 0, 0, 5};
    vecs[8]  = '{'{7'h6F, 3'd0, 7'h00, 1'b0, 2'd0}, 4, 0, 4, 1, 1, 0, 5};
    vecs[9]  = '{'{7'h67, 3'd0, 7'h00, 1'b0, 2'd0}, 4, 0, 0, 1, 1, 0, 5};
    vecs[10] = '{'{7'h37, 3'd0, 7'h00, 1'b0, 2'd0}, 2, 0, 0, 0, 1, 0, 5};
    vecs[11] = '{'{7'h17, 3'd0, 7'h00, 1'b0, 2'd0}, 0, 0, 1, 0, 1, 0, 5};
    vecs[12] = '{'{7'h03, 3'd4, 7'h00, 1'b0, 2'd0}, 8, 0, 0, 0, 1, 0, 7};
    vecs[13] = '{'{7'h03, 3'd1, 7'h00, 1'b0, 2'd0}, 5, 0, 0, 0, 1, 0, 7};
    vecs[14] = '{'{7'h23, 3'd0, 7'h00, 1'b0, 2'd2}, 0, 0, 0, 0, 0, 4, 7};
    vecs[15] = '{'{7'h23, 3'd1, 7'h00, 1'b0, 2'd2}, 0, 0, 0, 0, 0, 12, 7};
    vecs[16] = '{'{7'h7F, 3'd0, 7'h00, 1'b0, 2'd0}, 0, 0, 0, 0, 0, 0, 4};

    rst_n = 1'b0; opcode = 7'h00; funct3 = 3'd0; funct7 = 7'd0; br_en = 1'b0;
    mem_if.mem_resp = 1'b0; mem_if.mem_addr_lo = 2'd0;

    // Reset: loads and requests are all low, byte enables at their default.
    #2;
    chk("reset_loads_reqs",
        int'({load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
              mem_if.mem_read, mem_if.mem_write}), 0);
    chk("reset_byte_en", int'(mem_if.mem_byte_enable), 15);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);

    // addi x1,x0,5 with the fetch response three cycles late.
    in = '{7'h13, 3'd0, 7'h00, 1'b0, 2'd0};
    run_instr(in, 3, 0, r);
    chk("addi_wait.fetch_read_cycles", r.n_rd, 4);
    chk("addi_wait.cycles", r.cycles, 8);
    cmp_all("addi_wait", r, exp_of(in, 3, 0));

    // Table of single instructions with zero-wait memory.
    for (int i = 0; i < 17; i++) begin
      run_instr(vecs[i].in, 0, 0, r);
      chk($sformatf("vec%0d.regfilemux", i), r.rf, vecs[i].rf);
      chk($sformatf("vec%0d.aluop", i), r.aluop, vecs[i].aluop);
      chk($sformatf("vec%0d.alumux2", i), r.a2, vecs[i].a2);
      chk($sformatf("vec%0d.pcmux", i), r.pcmux, vecs[i].pcmux);
      chk($sformatf("vec%0d.n_regwr", i), r.n_rw, vecs[i].n_rw);
      chk($sformatf("vec%0d.byte_en", i), r.be, vecs[i].be);
      chk($sformatf("vec%0d.cycles", i), r.cycles, vecs[i].cycles);
    end

    // Store with a slow memory: mem_write held for every wait cycle, no reads.
    in = '{7'h23, 3'd0, 7'h00, 1'b0, 2'd2};
    run_instr(in, 0, 2, r);
    chk("sb_wait.write_cycles", r.n_wr, 3);
    chk("sb_wait.read_cycles", r.n_rd, 1);
    chk("sb_wait.byte_en", r.be, 4);

    // Illegal opcode: straight back to fetch, nothing architectural loaded.
    in = '{7'h7F, 3'd0, 7'h00, 1'b0, 2'd0};
    run_instr(in, 0, 0, r);
    chk("illegal.n_pcld", r.n_pc, 0);
    chk("illegal.n_regwr", r.n_rw, 0);

    // Reset asserted while LD1 is waiting on memory.
    opcode = 7'h03; funct3 = 3'd2; funct7 = 7'd0;
    mem_if.mem_resp = 1'b1;
    for (int e = 0; e < 4; e++) begin @(posedge clk); #1; end
    chk("ld_calc.mar_from_alu", int'({load_mar, marmux_sel}), 3);
    mem_if.mem_resp = 1'b0;
    @(posedge clk); #1;
    chk("ld1.mem_read", int'(mem_if.mem_read), 1);
    rst_n = 1'b0;
    #1;
    chk("ld1_reset.mem_read_drop", int'(mem_if.mem_read), 0);
    chk("ld1_reset.no_loads",
        int'({load_pc, load_ir, load_regfile, load_mdr, load_mar}), 0);
    @(posedge clk); #1;
    chk("ld1_reset.held_no_regwr", int'(load_regfile), 0);
    rst_n = 1'b1;
    #1;
    chk("ld1_reset.back_in_fetch1", int'({load_mar, marmux_sel, mem_if.mem_read}), 4);
    @(negedge clk);

    // Randomised instructions, wait states and stray mem_resp pulses.
    rand_resp = 1'b1;
    for (int n = 0; n < 80; n++) begin
      in = rand_instr();
      fw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      run_instr(in, fw, dw, r);
      cmp_all($sformatf("rnd%0d_op%02h_f%0d", n, in.op, in.f3), r, exp_of(in, fw, dw));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
